video_vga_scandouble: RTL
=========================

# video_vga_scandouble

Line-doubling stage directly downstream of the palette/frame mixer. It takes the mixer's blanked 6-bit colour at the TV pixel rate (7 MHz strobe on the 28 MHz clock) and stores each TV line in one half of a ping-pong line buffer. It replays the previous line twice at double rate (14 MHz), generating the VGA horizontal sync pulse for each replay. The result is 31 kHz VGA output from the 15.6 kHz TV raster.

## Interface
Parameters:
- DEPTH, 512, entries per line-buffer bank; power of two; address width AW = log2(DEPTH)
- HS_LEN, 96, VGA hsync pulse width in clk cycles

Ports:
- clk  in  1  28 MHz system clock
- rst  in  1  synchronous, active-high reset
- pix_stb  in  1  TV pixel strobe, one clk wide, nominally every 4th clk
- color  in  6  blanked {grn,red,blu} colour from the frame mixer; sampled when pix_stb=1
- hsync_start  in  1  one-clk pulse at start of each TV line
- vsync  in  1  TV vertical sync level
- vga_color  out  6  doubled-line colour; 0 when not replaying
- vga_hsync  out  1  VGA horizontal sync, active-high
- vga_vsync  out  1  vsync delayed 2 clk to match colour pipeline

## Operation
**Write side**
- wr_bank (1 bit) selects the bank being written; the read bank is always ~wr_bank.
- On pix_stb: write color to buffer[wr_bank][wr_cnt]; wr_cnt++ and saturate at DEPTH. Writes at wr_cnt==DEPTH are discarded.
- On hsync_start: len <= wr_cnt; wr_bank toggles; wr_cnt <= 0.
- If pix_stb and hsync_start occur in the same cycle, that pixel is written to address 0 of the new bank and wr_cnt becomes 1.
- line_ok <= 1 on every hsync_start, except the first one after reset, which leaves it 0. While line_ok=0, vga_color is forced to 0.

**Read FSM** (states IDLE, PASS0, PASS1, HOLD)
- IDLE: state after reset; vga_color=0; no hsync generated. Goes to PASS0 on hsync_start.
- PASS0 and PASS1:
  - rd_ptr starts at 0 and rd_phase at 0.
  - rd_phase toggles every clk; rd_ptr increments when rd_phase=1. Each entry is therefore addressed for 2 clk.
  - The pass ends on the cycle where rd_ptr==len-1 and rd_phase=1.
  - At the end of PASS0 the FSM goes to PASS1 (rd_ptr=0, rd_phase=0). At the end of PASS1 it goes to HOLD.
- len==0: PASS0 goes immediately to HOLD and no second hsync pulse is generated.
- HOLD: vga_color=0; wait for hsync_start.
- hsync_start in any state restarts PASS0 on the newly swapped read bank, aborting any pass in progress. This has priority over pass-end.
- vga_hsync: a counter loads HS_LEN on entry to PASS0 or PASS1 and counts down; vga_hsync=1 while the counter is nonzero. A restart reloads the counter.

**Arithmetic**
- wr_cnt and len are AW+1 bits wide.
- The RAM read is registered (1-clk latency). A second register produces vga_color, qualified by (state was PASS0/PASS1) & line_ok.

**Reset**
- vga_color=0, vga_hsync=0, vga_vsync=0.
- state=IDLE, wr_bank=0, wr_cnt=0, len=0, line_ok=0.
- Buffer contents are not cleared.
- Reset mid-line abandons both the write and the replay. Output stays blank until the second hsync_start after reset.

## Timing
- hsync_start at cycle T gives state PASS0 at T+1, with rd_ptr=0 presented at T+1 and T+2.
- vga_hsync=1 for cycles T+1 .. T+HS_LEN.
- vga_color shows buffer[0] at T+2 and T+3, buffer[k] at T+2+2k and T+3+2k.
- Pass duration is 2·len clk; PASS1 starts at T+1+2·len, and its hsync covers T+1+2·len .. T+2·len+HS_LEN.
- Nominal raster: 448 px/line, line 1792 clk, so PASS1 ends exactly as the next hsync_start arrives and HOLD is never entered.
- vga_vsync = vsync delayed 2 clk.

## Test plan
- Reset, then 3 lines of 448 strobes every 4 clk with color = pixel index mod 64 and hsync_start every 1792 clk:
  - line 1 output is all 0;
  - after the 2nd hsync_start (cycle T), vga_color = 0,0,1,1,2,2,…,63,63,0,… starting at T+2;
  - the same sequence repeats from T+898;
  - vga_hsync is high T+1..T+96 and T+897..T+992.
- Short line of 100 strobes, then hsync_start with the next hsync_start 1792 clk later:
  - passes end at T+200 and T+400;
  - vga_color=0 and vga_hsync=0 from T+402 until the next line.
- Overlong line of 600 strobes: len saturates at 512; entries 0..511 are replayed; the next hsync_start aborts PASS1 and PASS0 restarts cleanly.
- pix_stb coincident with hsync_start carrying color 6'h2A: the new line's first replayed pixel is 6'h2A and the line's len counts it.
- rst asserted mid-PASS1: the next cycle shows all outputs 0 and state IDLE; the first post-reset line is blank; the second line replays correctly.
- vsync toggled at cycle V: vga_vsync follows at V+2.

Source files
------------

// File: rtl/video_vga_scandouble.sv
// Purpose : doubles each TV line for 31 kHz VGA. Pixels are written into a
//           ping-pong line buffer at the 7 MHz strobe rate; the previous line
//           is replayed twice at 14 MHz, and each replay gets its own hsync pulse.
// Latency : hsync_start at T gives buffer[0] on vga_color at T+2/T+3 and vga_hsync from T+1.
// Backpr. : none; this is a free-running raster stage with no stall path.
// Ports   : clk, rst (sync, active-high), pix_stb/color (write side),
//           hsync_start/vsync (TV timing), vga_color/vga_hsync/vga_vsync (VGA out).
module video_vga_scandouble #(
    parameter int DEPTH  = 512,
    parameter int HS_LEN = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_stb,
    input  logic [5:0] color,
    input  logic       hsync_start,
    input  logic       vsync,
    output logic [5:0] vga_color,
    output logic       vga_hsync,
    output logic       vga_vsync
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HS_LEN + 1);

    typedef enum logic [1:0] {IDLE, PASS0, PASS1, HOLD} state_t;

    // Both banks live in one array; the MSB of the address selects the bank.
    logic [5:0]    mem [2*DEPTH];

    logic          wr_bank;
    logic [AW:0]   wr_cnt;
    logic [AW:0]   len;
    logic          first_seen;
    logic          line_ok;

    state_t        state, state_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic          rd_phase, rd_phase_nxt;
    logic          rd_bank_nxt;
    logic          hs_load;
    logic          pass_end;
    logic [HW-1:0] hs_cnt;
    logic [5:0]    ram_q;
    logic          vs_d1;

    // ---------------- write side ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            len        <= '0;
            first_seen <= 1'b0;
            line_ok    <= 1'b0;
        end else if (hsync_start) begin
            len        <= wr_cnt;
            wr_bank    <= ~wr_bank;
            // a pixel coincident with the line start belongs to the new line
            wr_cnt     <= pix_stb ? (AW+1)'(1) : '0;
            // the very first line after reset wrote into a bank of unknown history
            line_ok    <= first_seen;
            first_seen <= 1'b1;
        end else if (pix_stb && !wr_cnt[AW]) begin
            wr_cnt     <= wr_cnt + 1'b1;
        end
    end

    // The read bank is fetched with the *next* pointer so that the registered
    // RAM output lines up with rd_ptr one cycle earlier than a plain read would;
    // this keeps the total pointer-to-pixel latency at one clock.
    assign rd_bank_nxt = hsync_start ? wr_bank : ~wr_bank;

    always_ff @(posedge clk) begin
        if (!rst && pix_stb) begin
            if (hsync_start)
                mem[{~wr_bank, {AW{1'b0}}}] <= color;
            else if (!wr_cnt[AW])
                mem[{wr_bank, wr_cnt[AW-1:0]}] <= color;
        end
        ram_q <= mem[{rd_bank_nxt, rd_ptr_nxt}];
    end

    // ---------------- read FSM ----------------
    assign pass_end = rd_phase && ({1'b0, rd_ptr} == len - (AW+1)'(1));

    always_comb begin
        state_nxt    = state;
        rd_ptr_nxt   = rd_ptr;
        rd_phase_nxt = rd_phase;
        hs_load      = 1'b0;
        if (hsync_start) begin
            // restart wins over any pass-end in the same cycle
            state_nxt    = PASS0;
            rd_ptr_nxt   = '0;
            rd_phase_nxt = 1'b0;
            hs_load      = 1'b1;
        end else begin
            case (state)
                PASS0, PASS1: begin
                    if (state == PASS0 && len == '0) begin
                        state_nxt = HOLD;
                    end else if (pass_end) begin
                        state_nxt    = (state == PASS0) ? PASS1 : HOLD;
                        rd_ptr_nxt   = '0;
                        rd_phase_nxt = 1'b0;
                        hs_load      = (state == PASS0);
                    end else begin
                        rd_phase_nxt = ~rd_phase;
                        if (rd_phase)
                            rd_ptr_nxt = rd_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            rd_phase  <= 1'b0;
            hs_cnt    <= '0;
            vga_color <= '0;
            vs_d1     <= 1'b0;
            vga_vsync <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_phase <= rd_phase_nxt;
            if (hs_load)
                hs_cnt <= HW'(HS_LEN);
            else if (hs_cnt != '0)
                hs_cnt <= hs_cnt - 1'b1;
            vga_color <= ((state == PASS0 || state == PASS1) && line_ok) ? ram_q : '0;
            vs_d1     <= vsync;
            vga_vsync <= vs_d1;
        end
    end

    assign vga_hsync = (hs_cnt != '0);

endmodule
